// File: rtl/minc_trace_buffer_if.sv
// Read-side handshake of the minc trace buffer: captured entries leave oldest-first
// over a valid/ready pair.
interface minc_trace_buffer_if;
  logic        rd_valid;
  logic        rd_ready;
  logic [23:0] rd_data;

  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/minc_trace_buffer.sv
// Circular trace capture of the minc core debug outputs: records while armed, stops
// POST samples after a PC-match/forced trigger, then drains the window oldest-first.
module minc_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int POST   = 8
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic [7:0]          pc_in,
  input  logic [7:0]          top_in,
  input  logic [7:0]          sp_in,
  input  logic                capture_en,
  input  logic                arm,
  input  logic                trig_en,
  input  logic [7:0]          trig_pc,
  input  logic                trig_force,
  minc_trace_buffer_if.master rd,
  output logic [1:0]          state,
  output logic [ADDR_W:0]     count,
  output logic                wrapped
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [23:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [ADDR_W-1:0] rd_ptr_r, fetch_ptr_s;
  logic [ADDR_W:0]   count_r, count_nxt_s;
  logic [ADDR_W-1:0] post_cnt_r;
  logic              wrapped_r;
  logic              rd_valid_r;
  logic [23:0]       rd_data_r;

  logic full_s, clear_s, wr_en_s, post_load_s, post_dec_s, enter_read_s;
  logic rd_accept_s, rd_fetch_s, rd_drop_s;

  assign full_s = (count_r == (ADDR_W+1)'(DEPTH));

  // Next-state decode plus the per-cycle write/read strobes.
  always_comb begin
    state_nxt_s  = state_r;
    clear_s      = 1'b0;
    wr_en_s      = 1'b0;
    post_load_s  = 1'b0;
    post_dec_s   = 1'b0;
    enter_read_s = 1'b0;
    rd_accept_s  = 1'b0;
    rd_fetch_s   = 1'b0;
    rd_drop_s    = 1'b0;
    fetch_ptr_s  = rd_ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          clear_s     = 1'b1;
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (capture_en) begin
          wr_en_s = 1'b1;
          if ((trig_en && (pc_in == trig_pc)) || trig_force) begin
            post_load_s = 1'b1;
            if (POST == 0) begin
              state_nxt_s  = ST_READ;
              enter_read_s = 1'b1;
            end else begin
              state_nxt_s = ST_POST;
            end
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_POST: begin
        if (capture_en) begin
          wr_en_s    = 1'b1;
          post_dec_s = 1'b1;
          if (post_cnt_r == ADDR_W'(1)) begin
            state_nxt_s  = ST_READ;
            enter_read_s = 1'b1;
          end else begin
            state_nxt_s = ST_POST;
          end
        end else begin
          state_nxt_s = ST_POST;
        end
      end
      ST_READ: begin
        if (rd_valid_r) begin
          if (rd.rd_ready) begin
            rd_accept_s = 1'b1;
            if (count_r == (ADDR_W+1)'(1)) begin
              rd_drop_s   = 1'b1;
              state_nxt_s = ST_IDLE;
            end else begin
              rd_fetch_s  = 1'b1;
              fetch_ptr_s = rd_ptr_r + ADDR_W'(1);
            end
          end else begin
            state_nxt_s = ST_READ;
          end
        end else if (count_r == (ADDR_W+1)'(0)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          rd_fetch_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pointer/occupancy next values; full writes overwrite the oldest entry.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    count_nxt_s  = count_r;
    if (clear_s) begin
      wr_ptr_nxt_s = ADDR_W'(0);
      count_nxt_s  = (ADDR_W+1)'(0);
    end else if (wr_en_s) begin
      wr_ptr_nxt_s = wr_ptr_r + ADDR_W'(1);
      count_nxt_s  = full_s ? count_r : count_r + (ADDR_W+1)'(1);
    end else if (rd_accept_s) begin
      count_nxt_s = count_r - (ADDR_W+1)'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Control and read-port registers.
  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= ADDR_W'(0);
      rd_ptr_r   <= ADDR_W'(0);
      count_r    <= (ADDR_W+1)'(0);
      post_cnt_r <= ADDR_W'(0);
      wrapped_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= 24'd0;
    end else begin
      state_r  <= state_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      count_r  <= count_nxt_s;
      if (clear_s) begin
        wrapped_r <= 1'b0;
      end else if (wr_en_s && full_s) begin
        wrapped_r <= 1'b1;
      end
      if (post_load_s) begin
        post_cnt_r <= ADDR_W'(POST);
      end else if (post_dec_s) begin
        post_cnt_r <= post_cnt_r - ADDR_W'(1);
      end
      // Oldest entry sits count places behind the write pointer.
      if (enter_read_s) begin
        rd_ptr_r <= wr_ptr_nxt_s - count_nxt_s[ADDR_W-1:0];
      end else if (rd_accept_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      if (rd_fetch_s) begin
        rd_valid_r <= 1'b1;
        rd_data_r  <= mem_r[fetch_ptr_s];
      end else if (rd_drop_s) begin
        rd_valid_r <= 1'b0;
      end
    end
  end

  // Sample storage.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {pc_in, top_in, sp_in};
    end
  end

  assign rd.rd_valid = rd_valid_r;
  assign rd.rd_data  = rd_data_r;
  assign state       = state_r;
  assign count       = count_r;
  assign wrapped     = wrapped_r;

endmodule

// File: tb/tb_minc_trace_buffer.sv
// Directed bench for minc_trace_buffer: a reference queue of expected samples is filled
// while stimulus is driven and emptied against the DUT read port.
module tb_minc_trace_buffer;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int POST   = 8;

  logic            CLK = 1'b0;
  logic            nRESET = 1'b1;
  logic [7:0]      pc_in = 8'd0, top_in = 8'd0, sp_in = 8'd0, trig_pc = 8'd0;
  logic            capture_en = 1'b0, arm = 1'b0, trig_en = 1'b0, trig_force = 1'b0;
  logic [1:0]      state;
  logic [ADDR_W:0] count;
  logic            wrapped;

  minc_trace_buffer_if rif ();

  minc_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .POST(POST)) dut (
    .CLK(CLK), .nRESET(nRESET), .pc_in(pc_in), .top_in(top_in), .sp_in(sp_in),
    .capture_en(capture_en), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .trig_force(trig_force), .rd(rif), .state(state), .count(count), .wrapped(wrapped)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] exp_q[$];
  int          m_state = 0;
  int          m_post = 0;
  logic        m_wrapped = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] smp(input logic [7:0] p);
    return {p, ~p, p ^ 8'h5A};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_state   = 0;
    m_post    = 0;
    m_wrapped = 1'b0;
  endtask

  // One capture-side cycle: drive inputs, update the reference, check after the edge.
  task automatic step(input logic [7:0] p, input logic cen, input logic a,
                      input logic ten, input logic [7:0] tpc, input logic tf);
    @(negedge CLK);
    pc_in = p; top_in = ~p; sp_in = p ^ 8'h5A;
    capture_en = cen; arm = a; trig_en = ten; trig_pc = tpc; trig_force = tf;
    case (m_state)
      0: if (a) begin
        exp_q.delete();
        m_wrapped = 1'b0;
        m_state = 1;
      end
      1, 2: if (cen) begin
        exp_q.push_back(smp(p));
        if (exp_q.size() > DEPTH) begin
          void'(exp_q.pop_front());
          m_wrapped = 1'b1;
        end
        if (m_state == 1) begin
          if ((ten && (p == tpc)) || tf) begin
            m_post = POST;
            m_state = (POST == 0) ? 3 : 2;
          end
        end else begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end
      default: ;
    endcase
    @(posedge CLK);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("wrapped", 32'(wrapped), 32'(m_wrapped));
  endtask

  // Drain the window with a 4-cycle rd_ready pattern; optionally pulse arm at one cycle.
  task automatic drain(input logic [3:0] pat, input int arm_at);
    int          guard = 0;
    bit          done = 0;
    logic        v, rdy;
    logic [23:0] d, e;
    logic [ADDR_W:0] c;
    logic [1:0]  idx;
    capture_en = 1'b0; trig_force = 1'b0; trig_en = 1'b0;
    while (!done && guard < 200) begin
      @(negedge CLK);
      idx = guard[1:0];
      rdy = pat[idx];
      rif.rd_ready = rdy;
      arm = (guard == arm_at);
      v = rif.rd_valid; d = rif.rd_data; c = count;
      if (v && rdy) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(d), 32'(e));
        end else begin
          chk("unexpected_entry", 32'(v), 32'd0);
        end
      end
      @(posedge CLK);
      #1;
      if (v && rdy) chk("count_dec", 32'(count), 32'(c) - 32'd1);
      else          chk("count_hold", 32'(count), 32'(c));
      if (v && !rdy) begin
        chk("stall_valid", 32'(rif.rd_valid), 32'd1);
        chk("stall_data", 32'(rif.rd_data), 32'(d));
      end
      if (v && rdy && exp_q.size() == 0) done = 1;
      guard++;
    end
    chk("drain_done", 32'(done), 32'd1);
    chk("valid_low", 32'(rif.rd_valid), 32'd0);
    chk("state_idle", 32'(state), 32'd0);
    rif.rd_ready = 1'b0;
    arm = 1'b0;
    m_state = 0;
  endtask

  initial begin
    rif.rd_ready = 1'b0;
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rif.rd_valid), 32'd0);
    chk("rst_data", 32'(rif.rd_data), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);
    @(negedge CLK);
    nRESET = 1'b0;
    model_reset();

    // Asynchronous reset in the middle of a capture
    step(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 5; i++) step(8'(i), 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge CLK);
    #2 nRESET = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_valid", 32'(rif.rd_valid), 32'd0);
    chk("async_wrapped", 32'(wrapped), 32'd0);
    #3 nRESET = 1'b0;
    model_reset();

    // PC-match trigger with wrap: window 0x03..0x12
    step(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i <= 20; i++) step(8'(i), 1'b1, 1'b0, 1'b1, 8'h0A, 1'b0);
    chk("pcm_state", 32'(state), 32'd3);
    chk("pcm_count", 32'(count), 32'd16);
    chk("pcm_wrapped", 32'(wrapped), 32'd1);
    chk("pcm_first", 32'(rif.rd_data[23:16]), 32'h03);
    drain(4'b1111, -1);

    // Forced trigger on the 3rd sample, arm pulsed in POST and READ, stalled drain
    step(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i <= 10; i++)
      step(8'(8'h40 + i), 1'b1, (i == 5), 1'b0, 8'h00, (i == 2));
    chk("frc_state", 32'(state), 32'd3);
    chk("frc_count", 32'(count), 32'd11);
    chk("frc_wrapped", 32'(wrapped), 32'd0);
    drain(4'b1001, 2);

    // capture_en toggling; triggers on disabled cycles ignored
    step(8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i <= 30; i++)
      step(8'(8'h80 + i), ~i[0], 1'b0, 1'b1, 8'h83, (i == 5) || (i == 8));
    chk("tog_count", 32'(count), 32'd13);
    chk("tog_wrapped", 32'(wrapped), 32'd0);
    drain(4'b1011, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/minc_trace_buffer.md
Name: minc_trace_buffer

Overview:
Trace capture stage sitting directly downstream of the minc core. Samples the core's debug outputs (pc_out, top_out, sp_out) every enabled cycle into a circular buffer, stops a programmable number of samples after a PC-match trigger, then drains the captured window oldest-first over a valid/ready read port. Used by benches and on-chip debug in place of cycle-by-cycle $display monitoring.

Parameters:
DEPTH, 16, buffer entries; power of two, >= 4
ADDR_W, 4, log2(DEPTH)
POST, 8, samples captured after the trigger sample; legal range 0..DEPTH-1

Ports:
CLK  input  1  clock, all state updates on rising edge
nRESET  input  1  reset, asynchronous, active-high (1 = in reset)
pc_in  input  8  core pc_out
top_in  input  8  core top_out
sp_in  input  8  core sp_out
capture_en  input  1  sample qualifier; cycles with 0 are not recorded
arm  input  1  single-cycle start request
trig_en  input  1  enables PC-match trigger
trig_pc  input  8  trigger PC value
trig_force  input  1  immediate trigger regardless of PC
rd_valid  output  1  rd_data holds a valid entry
rd_ready  input  1  consumer accepts rd_data
rd_data  output  24  {pc, top, sp}, pc in [23:16]
state  output  2  0 IDLE, 1 ARMED, 2 POST, 3 READ
count  output  ADDR_W+1  entries currently held, 0..DEPTH
wrapped  output  1  at least one entry overwritten since arm

Behaviour:
- Reset (nRESET=1, async): state IDLE, wr_ptr 0, rd_ptr 0, count 0, post_cnt 0, rd_valid 0, rd_data 0, wrapped 0. Reset mid-capture or mid-readout discards everything; no partial drain.
- Sample = {pc_in, top_in, sp_in} written at wr_ptr on the rising edge; wr_ptr increments mod DEPTH.
- IDLE: no writes. arm=1 -> ARMED next cycle; count, wr_ptr and wrapped cleared on that edge. arm ignored in all other states.
- ARMED: each cycle with capture_en=1 writes one sample. count increments, saturating at DEPTH. A write with count==DEPTH overwrites the oldest entry and sets wrapped=1.
- Trigger: in ARMED, a cycle with capture_en=1 and ((trig_en=1 and pc_in==trig_pc) or trig_force=1) counts as a trigger. The trigger sample is written. Load post_cnt=POST. Next state is POST, or READ when POST==0. trig_force with capture_en=0 does not trigger.
- POST: each capture_en=1 cycle writes a sample with the same overwrite rules and decrements post_cnt. The write that takes post_cnt 1->0 moves state to READ. Trigger inputs are ignored here.
- READ entry: rd_ptr = wr_ptr - count (mod DEPTH), which is the oldest entry. rd_valid rises the cycle after entering READ, with rd_data registered from rd_ptr.
- Handshake: rd_data and rd_valid hold stable while rd_valid=1 and rd_ready=0. On rd_valid&rd_ready: rd_ptr++ and count--. The next entry is presented in the following cycle with rd_valid still 1, so full throughput is 1 entry/cycle. When the last entry is accepted: rd_valid=0 next cycle and state -> IDLE.
- READ with count==0 at entry (not reachable, since the trigger always writes): go directly to IDLE with rd_valid kept 0.
- No writes occur in READ or IDLE regardless of capture_en.
- Window size after trigger = min(pre-trigger samples + 1 + POST, DEPTH).

Test Plan:
- Reset mid-ARMED after 5 samples (assert nRESET=1 between edges) -> immediately state=0, count=0, rd_valid=0, wrapped=0, with no clock edge needed.
- Arm, capture_en=1, pc_in=0..20 incrementing, trig_pc=0x0A, trig_en=1, POST=8 -> state 3, count=16, wrapped=1; drained pc sequence 0x03..0x12 in order, rd_valid drops after 16 accepts, state 0.
- Arm, trig_force=1 on the 3rd enabled cycle, pc_in=0x40,0x41,... -> pre-window 0x40..0x42 plus 8 post samples; 11 entries, wrapped=0.
- capture_en toggling 1,0,1,0 with pc_in incrementing every cycle -> only even-cycle samples stored; the trigger on a capture_en=0 cycle is ignored.
- Readout with rd_ready toggling 1,0,0,1 -> rd_data stable while stalled; no entry duplicated or skipped; count decrements only on accept.
- arm pulsed during POST and during READ -> no effect on state, count or data.
